freq_gate_meter: RTL and testbench

//  Parametrised gate generator + edge counter for the frequency meter. Opens a gate of
//  run-time length (clk cycles), counts rising edges of an async test signal inside it,

---
 rtl/freq_meter_pkg.sv | 21 ++
 rtl/fm_edge_sync.sv | 36 +++
 rtl/freq_gate_meter.sv | 177 +++++++++++++++++
 tb/tb_freq_gate_meter.sv | 244 ++++++++++++++++++++++++
 4 files changed

// File: rtl/freq_meter_pkg.sv
// Shared types and constants for the frequency meter gate/edge-counter slice.
package freq_meter_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_GATE = 2'd1,
        ST_HOLD = 2'd2,
        ST_GAP  = 2'd3
    } state_e;

    localparam int unsigned DEF_LEN_W       = 28;
    localparam int unsigned DEF_CNT_W       = 32;
    localparam int unsigned DEF_SYNC_STAGES = 2;

    // Gate lengths in clk cycles at the nominal reference clock.
    localparam int unsigned CLK_HZ     = 100_000_000;
    localparam int unsigned GATE_1S    = 100_000_000;
    localparam int unsigned GATE_100MS = 10_000_000;
    localparam int unsigned GATE_10MS  = 1_000_000;

endpackage

// File: rtl/fm_edge_sync.sv
// Synchronises the asynchronous test signal and emits a registered one-cycle
// pulse per rising edge (latency SYNC_STAGES+1 clk cycles).
module fm_edge_sync #(
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic sig_in,
    output logic rise
);

    logic [SYNC_STAGES-1:0] sync_q, sync_d;
    logic                   last_q, last_d;
    logic                   rise_q, rise_d;

    always_comb begin
        sync_d = {sync_q[SYNC_STAGES-2:0], sig_in};
        last_d = sync_q[SYNC_STAGES-1];
        rise_d = sync_q[SYNC_STAGES-1] & ~last_q;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sync_q <= '0;
            last_q <= 1'b0;
            rise_q <= 1'b0;
        end else begin
            sync_q <= sync_d;
            last_q <= last_d;
            rise_q <= rise_d;
        end
    end

    assign rise = rise_q;

endmodule

// File: rtl/freq_gate_meter.sv
// Gate generator + edge counter for the frequency meter; single-shot or continuous.
// Define GATE_SYNC_EN to align gate open/close to signal rises (reciprocal mode).
module freq_gate_meter
    import freq_meter_pkg::*;
#(
    parameter int unsigned LEN_W       = DEF_LEN_W,
    parameter int unsigned CNT_W       = DEF_CNT_W,
    parameter int unsigned SYNC_STAGES = DEF_SYNC_STAGES
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             abort,
    input  logic             cont_mode,
    input  logic [LEN_W-1:0] gate_len,
    input  logic [LEN_W-1:0] idle_len,
    input  logic             sig_in,
    output logic             gate_en,
    output logic             busy,
    output logic [CNT_W-1:0] meas_cnt,
    output logic             meas_valid,
    output logic             meas_ovf,
    output logic [LEN_W-1:0] ref_cnt
);

    logic rise;

    fm_edge_sync #(
        .SYNC_STAGES(SYNC_STAGES)
    ) u_edge_sync (
        .clk   (clk),
        .rst_n (rst_n),
        .sig_in(sig_in),
        .rise  (rise)
    );

    state_e           state_q, state_d;
    logic             open_q, open_d;
    logic [LEN_W-1:0] op_q, op_d, len_q, len_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             gate_en_q, gate_en_d;
    logic             busy_q, busy_d;
    logic             meas_valid_q, meas_valid_d;
    logic [CNT_W-1:0] meas_cnt_q, meas_cnt_d;
    logic             meas_ovf_q, meas_ovf_d;
    logic [LEN_W-1:0] ref_cnt_q, ref_cnt_d;

    logic [LEN_W-1:0] op_inc, gate_len_eff, idle_len_eff;
    logic [CNT_W-1:0] cnt_inc;
    logic             close_ok;

`ifdef GATE_SYNC_EN
    // Gate waits for a rise to open and only closes on a rise.
    localparam logic OPEN_AT_ENTRY = 1'b0;
    assign close_ok = rise;
`else
    localparam logic OPEN_AT_ENTRY = 1'b1;
    assign close_ok = 1'b1;
`endif

    assign gate_len_eff = (gate_len == '0) ? LEN_W'(1) : gate_len;
    assign idle_len_eff = (idle_len == '0) ? LEN_W'(1) : idle_len;
    assign op_inc       = (&op_q) ? op_q : op_q + LEN_W'(1);
    assign cnt_inc      = (gate_en_q && rise && !(&cnt_q)) ? cnt_q + CNT_W'(1) : cnt_q;

    always_comb begin
        state_d      = state_q;
        open_d       = open_q;
        op_d         = op_q;
        len_d        = len_q;
        cnt_d        = cnt_q;
        meas_valid_d = 1'b0;
        meas_cnt_d   = meas_cnt_q;
        meas_ovf_d   = meas_ovf_q;
        ref_cnt_d    = ref_cnt_q;

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d = ST_GATE;
                    len_d   = gate_len_eff;
                    op_d    = '0;
                    cnt_d   = '0;
                    open_d  = OPEN_AT_ENTRY;
                end
            end
            ST_GATE: begin
                cnt_d = cnt_inc;
                if (open_q) begin
                    op_d = op_inc;
                    if (op_inc >= len_q && close_ok) begin
                        state_d      = ST_HOLD;
                        open_d       = 1'b0;
                        meas_valid_d = 1'b1;
                        meas_cnt_d   = cnt_inc;
                        meas_ovf_d   = &cnt_inc;
                        ref_cnt_d    = op_inc;
                    end
                end
`ifdef GATE_SYNC_EN
                else if (rise) begin
                    open_d = 1'b1;
                end
`endif
            end
            ST_HOLD: begin
                if (cont_mode) begin
                    state_d = ST_GAP;
                    len_d   = idle_len_eff;
                    op_d    = '0;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_GAP: begin
                op_d = op_inc;
                if (op_inc >= len_q) begin
                    state_d = ST_GATE;
                    len_d   = gate_len_eff;
                    op_d    = '0;
                    cnt_d   = '0;
                    open_d  = OPEN_AT_ENTRY;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        // Abort overrides everything and leaves the published result untouched.
        if (abort) begin
            state_d      = ST_IDLE;
            open_d       = 1'b0;
            meas_valid_d = 1'b0;
            meas_cnt_d   = meas_cnt_q;
            meas_ovf_d   = meas_ovf_q;
            ref_cnt_d    = ref_cnt_q;
        end

        gate_en_d = (state_d == ST_GATE) && open_d;
        busy_d    = (state_d != ST_IDLE);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q      <= ST_IDLE;
            open_q       <= 1'b0;
            op_q         <= '0;
            len_q        <= '0;
            cnt_q        <= '0;
            gate_en_q    <= 1'b0;
            busy_q       <= 1'b0;
            meas_valid_q <= 1'b0;
            meas_cnt_q   <= '0;
            meas_ovf_q   <= 1'b0;
            ref_cnt_q    <= '0;
        end else begin
            state_q      <= state_d;
            open_q       <= open_d;
            op_q         <= op_d;
            len_q        <= len_d;
            cnt_q        <= cnt_d;
            gate_en_q    <= gate_en_d;
            busy_q       <= busy_d;
            meas_valid_q <= meas_valid_d;
            meas_cnt_q   <= meas_cnt_d;
            meas_ovf_q   <= meas_ovf_d;
            ref_cnt_q    <= ref_cnt_d;
        end
    end

    assign gate_en    = gate_en_q;
    assign busy       = busy_q;
    assign meas_valid = meas_valid_q;
    assign meas_cnt   = meas_cnt_q;
    assign meas_ovf   = meas_ovf_q;
    assign ref_cnt    = ref_cnt_q;

endmodule

// File: tb/tb_freq_gate_meter.sv
// Directed self-checking bench for freq_gate_meter (CNT_W=4 to reach saturation).
module tb_freq_gate_meter;

    localparam int unsigned LEN_W  = 12;
    localparam int unsigned CNT_W  = 4;
    localparam int          BUDGET = 3000;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             start;
    logic             abort;
    logic             cont_mode;
    logic [LEN_W-1:0] gate_len;
    logic [LEN_W-1:0] idle_len;
    logic             sig_in = 1'b0;
    logic             gate_en;
    logic             busy;
    logic [CNT_W-1:0] meas_cnt;
    logic             meas_valid;
    logic             meas_ovf;
    logic [LEN_W-1:0] ref_cnt;

    int total = 0;
    int bad   = 0;
    int sig_per = 0;
    int ph = 0;

    always #5 clk = ~clk;

    freq_gate_meter #(
        .LEN_W      (LEN_W),
        .CNT_W      (CNT_W),
        .SYNC_STAGES(2)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .abort     (abort),
        .cont_mode (cont_mode),
        .gate_len  (gate_len),
        .idle_len  (idle_len),
        .sig_in    (sig_in),
        .gate_en   (gate_en),
        .busy      (busy),
        .meas_cnt  (meas_cnt),
        .meas_valid(meas_valid),
        .meas_ovf  (meas_ovf),
        .ref_cnt   (ref_cnt)
    );

    // Periodic test signal: one rise every sig_per clk cycles (0 = held low).
    always @(negedge clk) begin
        if (sig_per == 0) begin
            ph     = 0;
            sig_in = 1'b0;
        end else begin
            ph     = (ph + 1 >= sig_per) ? 0 : ph + 1;
            sig_in = (ph < sig_per / 2);
        end
    end

    typedef struct {
        int gl;
        int per;
        int exp_gate;
        int exp_cnt;
        int exp_ovf;
        int exp_ref;
    } vec_t;

    vec_t vecs[6];

    task automatic chk(input string name, input longint act, input longint exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic pulse_start();
        @(negedge clk) start = 1'b1;
        @(negedge clk) start = 1'b0;
    endtask

    task automatic run_level(input logic lvl, output int n);
        n = 0;
        while (gate_en === lvl && n < BUDGET) begin
            n++;
            @(negedge clk);
        end
    endtask

    task automatic set_sig(input int per);
        sig_per = per;
        repeat (10) @(negedge clk);
    endtask

    int  n, n2;
    logic saw;
    int  prev_cnt;

    initial begin
        rst_n = 1'b0; start = 1'b0; abort = 1'b0; cont_mode = 1'b0;
        gate_len = '0; idle_len = '0;

        vecs[0] = '{gl: 100, per: 10, exp_gate: 100, exp_cnt: 10, exp_ovf: 0, exp_ref: 100};
        vecs[1] = '{gl: 0,   per: 0,  exp_gate: 1,   exp_cnt: 0,  exp_ovf: 0, exp_ref: 1};
        vecs[2] = '{gl: 50,  per: 5,  exp_gate: 50,  exp_cnt: 10, exp_ovf: 0, exp_ref: 50};
        vecs[3] = '{gl: 64,  per: 2,  exp_gate: 64,  exp_cnt: 15, exp_ovf: 1, exp_ref: 64};
        vecs[4] = '{gl: 7,   per: 0,  exp_gate: 7,   exp_cnt: 0,  exp_ovf: 0, exp_ref: 7};
        vecs[5] = '{gl: 33,  per: 3,  exp_gate: 33,  exp_cnt: 11, exp_ovf: 0, exp_ref: 33};

        repeat (3) @(negedge clk);
        chk("rst_gate_en", gate_en, 0);
        chk("rst_busy", busy, 0);
        chk("rst_valid", meas_valid, 0);
        chk("rst_cnt", meas_cnt, 0);
        chk("rst_ovf", meas_ovf, 0);
        chk("rst_ref", ref_cnt, 0);
        rst_n = 1'b1;
        @(negedge clk);

`ifdef GATE_SYNC_EN
        gate_len = LEN_W'(30);
        set_sig(7);
        pulse_start();
        chk("sync_busy", busy, 1);
        n2 = 0;
        while (gate_en !== 1'b1 && n2 < 100) begin
            n2++;
            @(negedge clk);
        end
        chk("sync_open_timeout", (n2 < 100) ? 1 : 0, 1);
        run_level(1'b1, n);
        chk("sync_gate_cycles", n, 35);
        chk("sync_valid", meas_valid, 1);
        chk("sync_cnt", meas_cnt, 5);
        chk("sync_ref", ref_cnt, 35);
        @(negedge clk);
        chk("sync_idle", busy, 0);
`else
        // Single-shot table
        foreach (vecs[i]) begin
            gate_len = LEN_W'(vecs[i].gl);
            set_sig(vecs[i].per);
            pulse_start();
            run_level(1'b1, n);
            chk($sformatf("v%0d_gate_cycles", i), n, vecs[i].exp_gate);
            chk($sformatf("v%0d_valid", i), meas_valid, 1);
            chk($sformatf("v%0d_cnt", i), meas_cnt, vecs[i].exp_cnt);
            chk($sformatf("v%0d_ovf", i), meas_ovf, vecs[i].exp_ovf);
            chk($sformatf("v%0d_ref", i), ref_cnt, vecs[i].exp_ref);
            @(negedge clk);
            chk($sformatf("v%0d_valid_pulse", i), meas_valid, 0);
            chk($sformatf("v%0d_busy_end", i), busy, 0);
        end
        prev_cnt = vecs[5].exp_cnt;

        // Abort mid-gate: no result, old count kept
        gate_len = LEN_W'(100);
        set_sig(10);
        pulse_start();
        repeat (30) @(negedge clk);
        abort = 1'b1;
        @(negedge clk) abort = 1'b0;
        chk("abort_gate_en", gate_en, 0);
        chk("abort_busy", busy, 0);
        saw = 1'b0;
        for (int k = 0; k < 150; k++) begin
            @(negedge clk);
            if (meas_valid === 1'b1) saw = 1'b1;
        end
        chk("abort_no_valid", saw, 0);
        chk("abort_cnt_kept", meas_cnt, prev_cnt);

        // start and abort together in IDLE
        @(negedge clk) begin start = 1'b1; abort = 1'b1; end
        @(negedge clk) begin start = 1'b0; abort = 1'b0; end
        chk("start_abort_idle", busy, 0);
        @(negedge clk);
        chk("start_abort_idle2", gate_en, 0);

        // start while busy is ignored, gate_len not re-sampled
        gate_len = LEN_W'(40);
        pulse_start();
        repeat (9) @(negedge clk);
        gate_len = LEN_W'(200);
        start = 1'b1;
        @(negedge clk) start = 1'b0;
        run_level(1'b1, n);
        chk("busy_start_gate_cycles", n + 10, 40);
        chk("busy_start_cnt", meas_cnt, 4);
        chk("busy_start_ref", ref_cnt, 40);
        repeat (3) @(negedge clk);
        chk("busy_start_no_rearm", busy, 0);

        // Continuous mode: 50 open / 21 closed, then stop after current HOLD
        gate_len  = LEN_W'(50);
        idle_len  = LEN_W'(20);
        cont_mode = 1'b1;
        pulse_start();
        run_level(1'b1, n);
        chk("cont_gate1", n, 50);
        chk("cont_valid1", meas_valid, 1);
        chk("cont_cnt1", meas_cnt, 5);
        run_level(1'b0, n);
        chk("cont_gap1", n, 21);
        chk("cont_busy_gap", busy, 1);
        cont_mode = 1'b0;
        run_level(1'b1, n);
        chk("cont_gate2", n, 50);
        chk("cont_valid2", meas_valid, 1);
        chk("cont_ref2", ref_cnt, 50);
        @(negedge clk);
        chk("cont_stop_busy", busy, 0);

        // Reset mid-gate
        gate_len = LEN_W'(100);
        pulse_start();
        repeat (20) @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        chk("midrst_gate_en", gate_en, 0);
        chk("midrst_busy", busy, 0);
        chk("midrst_valid", meas_valid, 0);
        chk("midrst_cnt", meas_cnt, 0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        chk("midrst_stay_idle", busy, 0);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1);
    end

endmodule
